// File: rtl/necesidades_scheduler.sv
// rtl/necesidades_scheduler.sv - need-level sequencer: game tick, decay, round-robin care arbiter
// Optional macro ENFERMO_EN: double decay rate of the other needs while Medicina is empty.
module necesidades_scheduler #(
  parameter int TICK_DIV       = 50000000,
  parameter int TEST_DIV       = 50,
  parameter int DECAY_ANIMO    = 20,
  parameter int DECAY_ENERGIA  = 30,
  parameter int DECAY_DESCANSO = 45,
  parameter int DECAY_MEDICINA = 60,
  parameter int COOLDOWN_TICKS = 5
) (
  input  logic       clk,
  input  logic       B_Reset,
  input  logic       B_Test,
  input  logic       B_Energia,
  input  logic       B_Medicina,
  input  logic       Entrada_Animo,
  input  logic       Entrada_Descanso,
  output logic [1:0] LED_Animo,
  output logic [1:0] LED_Energia,
  output logic [1:0] LED_Descanso,
  output logic [1:0] LED_Medicina,
  output logic       tick,
  output logic [2:0] accion_ack,
  output logic [1:0] estado,
  output logic       alerta
);
  localparam int CW = 16;
  typedef logic [CW-1:0] cnt_t;
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, APPLY = 2'd2, COOLDOWN = 2'd3} state_t;

  localparam logic [31:0] TICK_LIM = 32'(TICK_DIV - 1);
  localparam logic [31:0] TEST_LIM = 32'(TEST_DIV - 1);
  localparam cnt_t CD_LIM = cnt_t'((COOLDOWN_TICKS > 0) ? COOLDOWN_TICKS - 1 : 0);
  // Need index: 0 Medicina, 1 Energia, 2 Animo, 3 Descanso (matches accion_ack bits)
  localparam cnt_t DEC_LIM [4] = '{cnt_t'(DECAY_MEDICINA - 1), cnt_t'(DECAY_ENERGIA - 1),
                                   cnt_t'(DECAY_ANIMO - 1), cnt_t'(DECAY_DESCANSO - 1)};
`ifdef ENFERMO_EN
  localparam cnt_t SICK_LIM [4] = '{cnt_t'(0),
                                    cnt_t'((DECAY_ENERGIA > 2) ? DECAY_ENERGIA - 2 : 0),
                                    cnt_t'((DECAY_ANIMO > 2) ? DECAY_ANIMO - 2 : 0),
                                    cnt_t'((DECAY_DESCANSO > 2) ? DECAY_DESCANSO - 2 : 0)};
`endif

  state_t      state, state_n;
  logic [31:0] pre, pre_lim;
  logic        test_q, test_chg;
  logic [2:0]  req_in, req_q, rise, pending, ack;
  logic [1:0]  ptr, pick, gsel;
  logic        found;
  cnt_t        cd_cnt;
  logic [1:0]  lvl [4];
  logic [1:0]  lvl_n [4];
  cnt_t        dcnt [4];
  cnt_t        cnt_n [4];
  cnt_t        lim, inc;
  int          j;

  // Prescaler; a B_Test change restarts the period and swallows that cycle's tick
  assign test_chg = B_Test ^ test_q;
  assign pre_lim  = B_Test ? TEST_LIM : TICK_LIM;
  assign tick     = !test_chg && (pre >= pre_lim);

  always_ff @(posedge clk) begin
    test_q <= B_Test;
    if (!B_Reset || test_chg || tick) pre <= '0;
    else                              pre <= pre + 32'd1;
  end

  assign req_in = {Entrada_Animo, B_Energia, B_Medicina};
  assign rise   = req_in & ~req_q;

  always_comb begin
    pick  = ptr;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < 3; k++) begin
      j = (int'(ptr) + k) % 3;
      if (!found && pending[j]) begin
        pick  = 2'(j);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!B_Reset) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    ack     = '0;
    case (state)
      IDLE:  if (|pending) state_n = GRANT;
      GRANT: begin
        ack     = 3'b001 << pick;
        state_n = APPLY;
      end
      APPLY: state_n = COOLDOWN;
      COOLDOWN: begin
        if (COOLDOWN_TICKS == 0)             state_n = IDLE;
        else if (tick && (cd_cnt == CD_LIM)) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    req_q <= req_in;
    if (!B_Reset) begin
      pending <= '0;
      ptr     <= 2'd0;
      gsel    <= 2'd0;
      cd_cnt  <= '0;
      alerta  <= 1'b0;
    end else begin
      // Clear before set so a same-cycle edge re-arms the granted requester
      pending <= (pending & ~ack) | rise;
      if (state == GRANT) begin
        gsel <= pick;
        ptr  <= (pick == 2'd2) ? 2'd0 : pick + 2'd1;
      end
      if (state != COOLDOWN) cd_cnt <= '0;
      else if (tick)         cd_cnt <= (cd_cnt == CD_LIM) ? '0 : cd_cnt + cnt_t'(1);
      alerta <= (lvl[0] == 2'd0) || (lvl[1] == 2'd0) || (lvl[2] == 2'd0) || (lvl[3] == 2'd0);
    end
  end

  always_comb begin
    lim = '0;
    inc = '0;
    for (int i = 0; i < 4; i++) begin
      lim = DEC_LIM[i];
      inc = cnt_t'(1);
`ifdef ENFERMO_EN
      if (i != 0 && lvl[0] == 2'd0) begin
        lim = SICK_LIM[i];
        inc = cnt_t'(2);
      end
`endif
      lvl_n[i] = lvl[i];
      cnt_n[i] = dcnt[i];
      if (i == 3 && Entrada_Descanso) begin
        cnt_n[i] = '0;
        if (tick && lvl[i] != 2'd3) lvl_n[i] = lvl[i] + 2'd1;
      end else if (!(i == 1 && Entrada_Descanso) && tick) begin
        if (dcnt[i] >= lim) begin
          cnt_n[i] = '0;
          if (lvl[i] != 2'd0) lvl_n[i] = lvl[i] - 2'd1;
        end else begin
          cnt_n[i] = dcnt[i] + inc;
        end
      end
      // Care overrides same-cycle decay of the granted need
      if (state == APPLY && gsel == 2'(i)) begin
        lvl_n[i] = (lvl[i] == 2'd3) ? 2'd3 : lvl[i] + 2'd1;
        cnt_n[i] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!B_Reset) begin
        lvl[i]  <= 2'd3;
        dcnt[i] <= '0;
      end else begin
        lvl[i]  <= lvl_n[i];
        dcnt[i] <= cnt_n[i];
      end
    end
  end

  assign LED_Medicina = lvl[0];
  assign LED_Energia  = lvl[1];
  assign LED_Animo    = lvl[2];
  assign LED_Descanso = lvl[3];
  assign accion_ack   = ack;
  assign estado       = state;
endmodule

// File: tb/tb_necesidades_scheduler.sv
// tb/tb_necesidades_scheduler.sv - randomized and directed bench with a behavioural need/arbiter model
module tb_necesidades_scheduler;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic B_Reset = 1'b0, B_Test = 1'b0, B_Energia = 1'b0, B_Medicina = 1'b0;
  logic Entrada_Animo = 1'b0, Entrada_Descanso = 1'b0;
  logic [1:0] LED_Animo, LED_Energia, LED_Descanso, LED_Medicina, estado;
  logic tick, alerta;
  logic [2:0] accion_ack;

  necesidades_scheduler #(
    .TICK_DIV(10), .TEST_DIV(2), .DECAY_ANIMO(3), .DECAY_ENERGIA(4),
    .DECAY_DESCANSO(6), .DECAY_MEDICINA(8), .COOLDOWN_TICKS(2)
  ) dut (
    .clk(clk), .B_Reset(B_Reset), .B_Test(B_Test), .B_Energia(B_Energia),
    .B_Medicina(B_Medicina), .Entrada_Animo(Entrada_Animo), .Entrada_Descanso(Entrada_Descanso),
    .LED_Animo(LED_Animo), .LED_Energia(LED_Energia), .LED_Descanso(LED_Descanso),
    .LED_Medicina(LED_Medicina), .tick(tick), .accion_ack(accion_ack), .estado(estado),
    .alerta(alerta)
  );

  int checks = 0, errors = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model. Needs: 0 Medicina, 1 Energia, 2 Animo, 3 Descanso.
  localparam int PER [4] = '{8, 4, 3, 6};
  localparam int CD_TICKS = 2;
  int m_lvl [4], m_cnt [4], m_prev [3], m_pend [3];
  int m_pre, m_tprev, m_phase, m_ptr, m_gnt, m_cdleft, m_alerta;
  bit m_valid = 0;
  int e_tick, e_pick, e_ack;
  int obs_ack, obs_estado, obs_tick;

  task automatic model_comb();
    int div;
    div    = B_Test ? 2 : 10;
    e_tick = (int'(B_Test) == m_tprev && m_pre == div - 1) ? 1 : 0;
    e_pick = -1;
    for (int k = 0; k < 3; k++)
      if (e_pick < 0 && m_pend[(m_ptr + k) % 3] != 0) e_pick = (m_ptr + k) % 3;
    e_ack = (m_phase == 1 && e_pick >= 0) ? (1 << e_pick) : 0;
  endtask

  task automatic model_seq();
    int req [3];
    int old_lvl [4];
    int any_pend, sleep;
    req[0] = int'(B_Medicina); req[1] = int'(B_Energia); req[2] = int'(Entrada_Animo);
    sleep = int'(Entrada_Descanso);
    if (!B_Reset) begin
      for (int i = 0; i < 4; i++) begin m_lvl[i] = 3; m_cnt[i] = 0; end
      for (int i = 0; i < 3; i++) begin m_prev[i] = req[i]; m_pend[i] = 0; end
      m_pre = 0; m_tprev = int'(B_Test); m_phase = 0; m_ptr = 0; m_gnt = 0;
      m_cdleft = 0; m_alerta = 0; m_valid = 1;
      return;
    end
    model_comb();
    m_alerta = 0;
    for (int i = 0; i < 4; i++) begin
      old_lvl[i] = m_lvl[i];
      if (m_lvl[i] == 0) m_alerta = 1;
    end
    for (int i = 0; i < 4; i++) begin
      if (i == 3 && sleep != 0) begin
        m_cnt[i] = 0;
        if (e_tick != 0 && m_lvl[i] < 3) m_lvl[i]++;
      end else if (i == 1 && sleep != 0) begin
      end else if (e_tick != 0) begin
        m_cnt[i]++;
        if (m_cnt[i] == PER[i]) begin
          m_cnt[i] = 0;
          if (m_lvl[i] > 0) m_lvl[i]--;
        end
      end
      if (m_phase == 2 && m_gnt == i) begin
        m_lvl[i] = (old_lvl[i] < 3) ? old_lvl[i] + 1 : 3;
        m_cnt[i] = 0;
      end
    end
    any_pend = m_pend[0] | m_pend[1] | m_pend[2];
    if (m_phase == 1 && e_pick >= 0) m_pend[e_pick] = 0;
    for (int i = 0; i < 3; i++) begin
      if (req[i] != 0 && m_prev[i] == 0) m_pend[i] = 1;
      m_prev[i] = req[i];
    end
    case (m_phase)
      0: if (any_pend != 0) m_phase = 1;
      1: begin m_gnt = e_pick; m_ptr = (e_pick + 1) % 3; m_phase = 2; end
      2: begin m_phase = 3; m_cdleft = CD_TICKS; end
      default: begin
        if (m_cdleft == 0) m_phase = 0;
        else if (e_tick != 0) begin
          m_cdleft--;
          if (m_cdleft == 0) m_phase = 0;
        end
      end
    endcase
    if (int'(B_Test) != m_tprev || e_tick != 0) m_pre = 0;
    else m_pre++;
    m_tprev = int'(B_Test);
  endtask

  task automatic cycle_step(input logic r, input logic t, input logic e, input logic m,
                            input logic a, input logic d);
    @(negedge clk);
    B_Reset = r; B_Test = t; B_Energia = e; B_Medicina = m; Entrada_Animo = a; Entrada_Descanso = d;
    #1;
    obs_ack = int'(accion_ack); obs_estado = int'(estado); obs_tick = int'(tick);
    if (m_valid) begin
      model_comb();
      check("led_medicina", LED_Medicina, m_lvl[0]);
      check("led_energia", LED_Energia, m_lvl[1]);
      check("led_animo", LED_Animo, m_lvl[2]);
      check("led_descanso", LED_Descanso, m_lvl[3]);
      check("tick", tick, e_tick);
      check("accion_ack", accion_ack, e_ack);
      check("estado", estado, m_phase);
      check("alerta", alerta, m_alerta);
    end
    @(posedge clk);
    model_seq();
  endtask

  initial begin
    int n, first, found;
    int acks [$];
    int exp_acks [4] = '{1, 2, 4, 1};

    // Reset and normal-mode tick period
    repeat (3) cycle_step(0, 0, 0, 0, 0, 0);
    #1;
    check("rst_led_animo", LED_Animo, 3);
    check("rst_led_energia", LED_Energia, 3);
    check("rst_led_descanso", LED_Descanso, 3);
    check("rst_led_medicina", LED_Medicina, 3);
    check("rst_estado", estado, 0);
    check("rst_ack", accion_ack, 0);
    check("rst_alerta", alerta, 0);
    n = 0; first = -1;
    for (int c = 0; c < 30; c++) begin
      cycle_step(1, 0, 0, 0, 0, 0);
      if (obs_tick != 0) begin n++; if (first < 0) first = c; end
    end
    check("tick_count_30clk", n, 3);
    check("first_tick_index", first, 9);

    // Contention: Medicina before Energia, then Animo beats a new Medicina
    repeat (2) cycle_step(0, 1, 0, 0, 0, 0);
    n = 0;
    for (int c = 0; c < 150 && acks.size() < 4; c++) begin
      if (acks.size() < 2) cycle_step(1, 1, 1, 1, 0, 0);
      else if (n++ == 0)   cycle_step(1, 1, 0, 0, 0, 0);
      else                 cycle_step(1, 1, 0, 1, 1, 0);
      if (obs_ack != 0) acks.push_back(obs_ack);
    end
    check("contention_ack_count", acks.size(), 4);
    for (int k = 0; k < 4; k++)
      check("contention_ack_order", (k < acks.size()) ? acks[k] : -1, exp_acks[k]);

    // Reset in APPLY and in COOLDOWN with Energia pending
    for (int tgt = 2; tgt <= 3; tgt++) begin
      cycle_step(0, 1, 0, 0, 0, 0);
      cycle_step(1, 1, 0, 0, 0, 0);
      found = 0;
      for (int c = 0; c < 40 && found == 0; c++) begin
        cycle_step(1, 1, 1, 1, 0, 0);
        if (obs_estado == tgt) found = 1;
      end
      check("reach_state", found, 1);
      cycle_step(0, 1, 1, 1, 0, 0);
      n = 0;
      for (int c = 0; c < 20; c++) begin
        cycle_step(1, 1, 1, 1, 0, 0);
        if (obs_ack != 0) n++;
      end
      check("no_ack_after_reset", n, 0);
    end

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      cycle_step(logic'($urandom_range(0, 499) != 0),
                 B_Test ^ logic'($urandom_range(0, 199) == 0),
                 B_Energia ^ logic'($urandom_range(0, 5) == 0),
                 B_Medicina ^ logic'($urandom_range(0, 7) == 0),
                 Entrada_Animo ^ logic'($urandom_range(0, 4) == 0),
                 Entrada_Descanso ^ logic'($urandom_range(0, 63) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
